// File: rtl/reg_xfer_sched_pkg.sv
// rtl/reg_xfer_sched_pkg.sv - control package: register ops and scheduler states
package control;

  typedef enum logic [1:0] {
    NOP    = 2'd0,
    ENABLE = 2'd1,
    LOAD   = 2'd2
  } reg_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    MOVE  = 2'd2,
    ACK   = 2'd3
  } sched_state_e;

  localparam int BUS_W = 8;

  // Index width that stays legal for single-entry configurations
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_xfer_sched_if.sv
// rtl/reg_xfer_sched_if.sv - requester handshake and register bus bundle
interface reg_xfer_sched_if import control::*; #(
  parameter int NUM_REGS = 4,
  parameter int NUM_REQ  = 2
);
  localparam int IDX_W = idx_w(NUM_REGS);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0][IDX_W-1:0] src;
  logic [NUM_REQ-1:0][IDX_W-1:0] dst;
  logic [NUM_REQ-1:0]            imm_en;
  logic [NUM_REQ-1:0][BUS_W-1:0] imm;
  logic [NUM_REQ-1:0]            ack;
  logic [NUM_REQ-1:0]            err;
  reg_op_e                       reg_op [NUM_REGS];
  logic                          bus_drive;
  logic [BUS_W-1:0]              bus_data;
  logic                          busy;

  modport master (
    output req, src, dst, imm_en, imm,
    input  ack, err, reg_op, bus_drive, bus_data, busy
  );

  modport slave (
    input  req, src, dst, imm_en, imm,
    output ack, err, reg_op, bus_drive, bus_data, busy
  );

endinterface

// File: rtl/reg_xfer_sched_rr_arbiter.sv
// rtl/reg_xfer_sched_rr_arbiter.sv - combinational round-robin arbiter, search starts at ptr
module rr_arbiter #(
  parameter int N     = 2,
  parameter int PTR_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  logic [2*N-1:0] rot;
  logic [N-1:0]   first;
  logic [2*N-1:0] oh_wide;

  // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back
  always_comb begin
    rot     = {req, req} >> ptr;
    first   = rot[N-1:0] & (~rot[N-1:0] + N'(1));
    oh_wide = {{N{1'b0}}, first} << ptr;
    gnt     = oh_wide[N-1:0] | oh_wide[2*N-1:N];
  end

endmodule

// File: rtl/reg_xfer_sched.sv
// rtl/reg_xfer_sched.sv - schedules register-to-register and immediate moves on a shared 8-bit bus
module reg_xfer_sched import control::*; #(
  parameter int NUM_REGS = 4,
  parameter int NUM_REQ  = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  reg_xfer_sched_if.slave  xif
);

  localparam int IDX_W = idx_w(NUM_REGS);
  localparam int PTR_W = idx_w(NUM_REQ);

  sched_state_e       state, state_nx;
  logic [PTR_W-1:0]   rr_ptr, win;
  logic [NUM_REQ-1:0] gnt, owner;
  logic [IDX_W-1:0]   src_q, dst_q, sel_src, sel_dst;
  logic [BUS_W-1:0]   imm_q, sel_imm;
  logic               imm_en_q, sel_imm_en, bad_q, sel_bad;

  rr_arbiter #(.N(NUM_REQ), .PTR_W(PTR_W)) u_arb (
    .req (xif.req),
    .ptr (rr_ptr),
    .gnt (gnt)
  );

  always_comb begin
    sel_src    = '0;
    sel_dst    = '0;
    sel_imm    = '0;
    sel_imm_en = 1'b0;
    win        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_src    = xif.src[i];
        sel_dst    = xif.dst[i];
        sel_imm    = xif.imm[i];
        sel_imm_en = xif.imm_en[i];
        win        = PTR_W'(i);
      end
    end
    // Self-moves and out-of-range indices complete at once with err and touch no register
    sel_bad = (int'(sel_dst) >= NUM_REGS) ||
              (!sel_imm_en && ((int'(sel_src) >= NUM_REGS) || (sel_src == sel_dst)));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr   <= '0;
      owner    <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      imm_q    <= '0;
      imm_en_q <= 1'b0;
      bad_q    <= 1'b0;
    end else if (state == IDLE && |xif.req) begin
      rr_ptr   <= (int'(win) == NUM_REQ - 1) ? '0 : win + PTR_W'(1);
      owner    <= gnt;
      src_q    <= sel_src;
      dst_q    <= sel_dst;
      imm_q    <= sel_imm;
      imm_en_q <= sel_imm_en;
      bad_q    <= sel_bad;
    end
  end

  always_comb begin
    state_nx      = state;
    xif.bus_drive = 1'b0;
    xif.bus_data  = '0;
    xif.ack       = '0;
    xif.err       = '0;
    xif.busy      = (state != IDLE);
    for (int r = 0; r < NUM_REGS; r++) xif.reg_op[r] = NOP;

    case (state)
      IDLE: begin
        if (|xif.req) state_nx = sel_bad ? ACK : (sel_imm_en ? MOVE : FETCH);
      end
      FETCH: begin
        state_nx = MOVE;
        for (int r = 0; r < NUM_REGS; r++)
          if (src_q == IDX_W'(r)) xif.reg_op[r] = ENABLE;
      end
      MOVE: begin
        state_nx = ACK;
        // Source keeps the bus valid for a register move; the immediate drives it otherwise
        for (int r = 0; r < NUM_REGS; r++) begin
          if (dst_q == IDX_W'(r))                     xif.reg_op[r] = LOAD;
          else if (!imm_en_q && src_q == IDX_W'(r))   xif.reg_op[r] = ENABLE;
        end
        xif.bus_drive = imm_en_q;
        xif.bus_data  = imm_en_q ? imm_q : '0;
      end
      ACK: begin
        state_nx = IDLE;
        xif.ack  = owner;
        xif.err  = bad_q ? owner : '0;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_reg_xfer_sched.sv
// tb/tb_reg_xfer_sched.sv - vector table plus ack scoreboard for reg_xfer_sched
module tb_reg_xfer_sched;
  import control::*;

  localparam int NREG = 4;
  localparam int NREQ = 2;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  reg_xfer_sched_if #(.NUM_REGS(NREG), .NUM_REQ(NREQ)) xif ();

  reg_xfer_sched #(.NUM_REGS(NREG), .NUM_REQ(NREQ)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .xif     (xif)
  );

  typedef struct {
    logic [NREQ-1:0] ack;
    logic [NREQ-1:0] err;
  } sb_t;

  typedef struct {
    logic [0:0] rq;
    logic [1:0] s;
    logic [1:0] d;
    bit         ie;
    logic [7:0] im;
    bit         bad;
    int         lat;
  } vec_t;

  sb_t  sb_q [$];
  vec_t vecs [7];
  int   n_chk = 0;
  int   n_fail = 0;

  // Behavioural reg_acc bank on the shared bus
  logic [7:0] regs   [NREG] = '{8'h10, 8'h21, 8'h32, 8'h43};
  logic [7:0] shadow [NREG] = '{8'h10, 8'h21, 8'h32, 8'h43};
  logic [7:0] bus_val;

  always_comb begin
    bus_val = xif.bus_drive ? xif.bus_data : 8'h00;
    for (int r = 0; r < NREG; r++)
      if (xif.reg_op[r] == ENABLE) bus_val = regs[r];
  end

  always @(posedge clock)
    for (int r = 0; r < NREG; r++)
      if (xif.reg_op[r] == LOAD) regs[r] <= bus_val;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  function automatic logic [2*NREG-1:0] ops_now();
    logic [2*NREG-1:0] v;
    v = '0;
    for (int r = 0; r < NREG; r++) v[2*r +: 2] = xif.reg_op[r];
    return v;
  endfunction

  function automatic logic [31:0] word_now();
    return 32'({ops_now(), xif.bus_drive, xif.bus_data, xif.busy});
  endfunction

  function automatic logic [31:0] want_word(input int n, input vec_t v);
    logic [2*NREG-1:0] op;
    logic              drv;
    logic [7:0]        data;
    op = '0; drv = 1'b0; data = 8'h00;
    if (!v.bad) begin
      if (v.ie) begin
        if (n == 1) begin op[2*int'(v.d) +: 2] = LOAD; drv = 1'b1; data = v.im; end
      end else begin
        if (n == 1) op[2*int'(v.s) +: 2] = ENABLE;
        if (n == 2) begin op[2*int'(v.s) +: 2] = ENABLE; op[2*int'(v.d) +: 2] = LOAD; end
      end
    end
    return 32'({op, drv, data, 1'b1});
  endfunction

  // Per-cycle bus safety plus in-order ack/err scoreboard
  always @(negedge clock) begin : mon
    int   loads;
    logic en;
    sb_t  e;
    if (reset_n) begin
      loads = 0;
      en    = 1'b0;
      for (int r = 0; r < NREG; r++) begin
        if (xif.reg_op[r] == LOAD)   loads++;
        if (xif.reg_op[r] == ENABLE) en = 1'b1;
      end
      chk("load_onehot", 32'(loads > 1), 32'd0);
      chk("drive_vs_enable", 32'(xif.bus_drive & en), 32'd0);
      if (xif.ack != '0) begin
        if (sb_q.size() == 0) chk("unexpected_ack", 32'(xif.ack), 32'd0);
        else begin
          e = sb_q.pop_front();
          chk("sb_ack", 32'(xif.ack), 32'(e.ack));
          chk("sb_err", 32'(xif.err), 32'(e.err));
        end
      end else begin
        chk("err_without_ack", 32'(xif.err), 32'd0);
      end
    end
  end

  task automatic xfer(input int idx, input vec_t v);
    sb_t e;
    @(posedge clock); #1;
    xif.src[v.rq]    = v.s;
    xif.dst[v.rq]    = v.d;
    xif.imm_en[v.rq] = v.ie;
    xif.imm[v.rq]    = v.im;
    xif.req[v.rq]    = 1'b1;
    e.ack = NREQ'(1) << v.rq;
    e.err = v.bad ? e.ack : '0;
    sb_q.push_back(e);
    @(posedge clock); #1;
    // Grant has happened: drop req and disturb the fields, transfer must be unaffected
    xif.req[v.rq]    = 1'b0;
    xif.src[v.rq]    = ~v.s;
    xif.dst[v.rq]    = ~v.d;
    xif.imm_en[v.rq] = ~v.ie;
    xif.imm[v.rq]    = ~v.im;
    for (int n = 1; n <= v.lat; n++) begin
      @(negedge clock);
      chk($sformatf("v%0d_cycle%0d_ops", idx, n), word_now(), want_word(n, v));
    end
    @(negedge clock);
    chk($sformatf("v%0d_idle_after", idx), 32'(xif.busy), 32'd0);
    if (!v.bad) shadow[v.d] = v.ie ? v.im : shadow[v.s];
    for (int r = 0; r < NREG; r++)
      chk($sformatf("v%0d_r%0d", idx, r), 32'(regs[r]), 32'(shadow[r]));
  endtask

  initial begin
    int got;
    //           rq    s     d     ie  im     bad lat
    vecs[0] = '{1'b0, 2'd1, 2'd2, 0, 8'h00, 0, 3};
    vecs[1] = '{1'b1, 2'd0, 2'd3, 1, 8'hA5, 0, 2};
    vecs[2] = '{1'b0, 2'd2, 2'd2, 0, 8'h00, 1, 1};
    vecs[3] = '{1'b1, 2'd3, 2'd0, 0, 8'h00, 0, 3};
    vecs[4] = '{1'b0, 2'd0, 2'd1, 1, 8'h5A, 0, 2};
    vecs[5] = '{1'b1, 2'd2, 2'd2, 1, 8'h7E, 0, 2};
    vecs[6] = '{1'b0, 2'd0, 2'd3, 0, 8'h00, 0, 3};

    xif.req = '0; xif.src = '0; xif.dst = '0; xif.imm_en = '0; xif.imm = '0;

    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_held_word", word_now(), 32'd0);
    chk("rst_held_ack_err", 32'({xif.ack, xif.err}), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("rst_release_word", word_now(), 32'd0);

    for (int i = 0; i < 7; i++) xfer(i, vecs[i]);

    // Reset in MOVE: requester 0 leaves rr_ptr at 1, reset must bring it back to 0
    @(posedge clock); #1;
    xif.src[0] = 2'd0; xif.dst[0] = 2'd3; xif.imm_en[0] = 1'b0; xif.req[0] = 1'b1;
    @(posedge clock); #1;
    xif.req[0] = 1'b0;
    @(posedge clock); #1;
    chk("move_before_rst", 32'(ops_now()), 32'(8'b10_00_00_01));
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("rst_in_move_word", word_now(), 32'd0);
    chk("rst_in_move_ack", 32'({xif.ack, xif.err}), 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    chk("rst_in_move_no_load", 32'(regs[3]), 32'(shadow[3]));

    // Both requesters held: grants must alternate starting from 0
    xif.src = '0;
    xif.dst[0] = 2'd0; xif.imm[0] = 8'h3C;
    xif.dst[1] = 2'd1; xif.imm[1] = 8'hC3;
    xif.imm_en = 2'b11;
    for (int k = 0; k < 4; k++) sb_q.push_back('{ack: (k % 2 == 0) ? 2'b01 : 2'b10, err: 2'b00});
    xif.req = 2'b11;
    got = 0;
    for (int n = 0; n < 20 && got < 4; n++) begin
      @(negedge clock);
      if (xif.ack != '0) got++;
    end
    xif.req = '0;
    chk("rr_ack_count", 32'(got), 32'd4);
    repeat (2) @(negedge clock);
    shadow[0] = 8'h3C;
    shadow[1] = 8'hC3;
    for (int r = 0; r < NREG; r++)
      chk($sformatf("rr_r%0d", r), 32'(regs[r]), 32'(shadow[r]));
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
